// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first, WIDTH clocks per add.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic fa_s;
  logic fa_c;

  assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // sum/c_out are separate from the shift register so a finished result stays
  // stable until the following operation completes or reset hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      c_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            sum_sr <= '0;
            carry  <= c_in;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {fa_s, sum_sr[WIDTH-1:1]};
            c_out <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry flop still holds the carry into the MSB at this edge
            ovf   <= carry ^ fa_c;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed+random ops and a WIDTH=2 full-adder table.
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic       st8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       st2, ci2, busy2, done2, co2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] q8[$];
  logic [3:0] q2[$];
  logic       prev_done8;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .c_in(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(co8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .c_in(ci2),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(co2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition; signed overflow from operand/result signs.
  function automatic logic [9:0] exp8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    logic [8:0] t;
    t = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    return {(av[7] == bv[7]) && (t[7] != av[7]), t};
  endfunction

  function automatic logic [3:0] exp2(input logic [1:0] av, input logic [1:0] bv, input logic cv);
    logic [2:0] t;
    t = {1'b0, av} + {1'b0, bv} + {2'd0, cv};
    return {(av[1] == bv[1]) && (t[1] != av[1]), t};
  endfunction

  // Monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && done8) begin
      chk("done8_single_pulse", {31'd0, prev_done8}, 32'd0);
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("sum8", {24'd0, sum8}, {24'd0, e[7:0]});
        chk("cout8", {31'd0, co8}, {31'd0, e[8]});
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf8", {31'd0, ovf8}, {31'd0, e[9]});
`endif
      end
    end
    prev_done8 <= rst_n & done8;
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        chk("done2_unexpected", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        chk("fa_sum_bit0", {31'd0, sum2[0]}, {31'd0, e[0]});
        chk("fa_carry_into_bit1", {31'd0, sum2[1]}, {31'd0, e[1]});
        chk("cout2", {31'd0, co2}, {31'd0, e[2]});
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf2", {31'd0, ovf2}, {31'd0, e[3]});
`endif
      end
    end
  end

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    st8 = 1'b1; a8 = av; b8 = bv; ci8 = cv;
    @(posedge clk);
    q8.push_back(exp8(av, bv, cv));
    #1;
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
  endtask

  // Issues one op, optionally re-pulses start during RUN cycle `glitch`,
  // and returns at the negedge of the DONE cycle.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input int glitch);
    issue8(av, bv, cv);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        st8 = 1'b1; a8 = 8'hFF; b8 = 8'($urandom); ci8 = 1'($urandom);
      end
      @(negedge clk);
      chk("busy_in_run", {31'd0, busy8}, 32'd1);
      chk("done_low_in_run", {31'd0, done8}, 32'd0);
      @(posedge clk);
      #1;
      st8 = 1'b0;
    end
    @(negedge clk);
    chk("done_latency", {31'd0, done8}, 32'd1);
    chk("busy_low_in_done", {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    st8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    st2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_sum8", {24'd0, sum8}, 32'd0);
    chk("rst_cout8", {31'd0, co8}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(8'h00, 8'h00, 1'b0, -1);
    repeat (1) @(negedge clk);
    chk("idle_after_done", {31'd0, done8}, 32'd0);
    run8(8'hFF, 8'h01, 1'b0, -1);
    run8(8'h5A, 8'hA5, 1'b1, -1);      // back-to-back from DONE
    repeat (2) @(negedge clk);
    chk("sum_holds_idle", {24'd0, sum8}, 32'd0);
    chk("cout_holds_idle", {31'd0, co8}, 32'd1);
    run8(8'h12, 8'h34, 1'b0, 3);       // start re-pulsed mid-RUN is ignored
    run8(8'h7F, 8'h01, 1'b0, -1);
    run8(8'hFF, 8'h01, 1'b0, -1);
    run8(8'h80, 8'h80, 1'b1, -1);

    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      run8(8'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    // Reset during the 3rd RUN cycle after a nonzero result is on the outputs
    run8(8'h3C, 8'h41, 1'b0, -1);
    issue8(8'($urandom), 8'($urandom), 1'($urandom));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {31'd0, busy8}, 32'd0);
    chk("midrun_rst_done", {31'd0, done8}, 32'd0);
    chk("midrun_rst_sum", {24'd0, sum8}, 32'd0);
    chk("midrun_rst_cout", {31'd0, co8}, 32'd0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h03, 8'h04, 1'b0, -1);

    // WIDTH=2 full-adder truth table on bit 0
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      @(negedge clk);
      st2 = 1'b1; a2 = {1'b0, v[0]}; b2 = {1'b0, v[1]}; ci2 = v[2];
      @(posedge clk);
      q2.push_back(exp2(a2, b2, ci2));
      #1;
      st2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); ci2 = 1'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("done2_latency", {31'd0, done2}, 32'd1);
    end

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
